// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine among NREQ byte sources.
// Issues a one-cycle load/ack pair per grant and counts the bytes handed over.
module uart_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int GUARD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic              TxRdy,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [15:0]       sent_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH} state_e;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(GUARD + 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [15:0]     sent_cnt_q, sent_cnt_d;
  logic [GW-1:0]   guard_q, guard_d;

  logic            grant_valid;
  logic [IW-1:0]   grant_idx;

  // Search starts just after the previous winner so every source gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      if (!grant_valid && req[(int'(last_q) + i) % NREQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((int'(last_q) + i) % NREQ);
      end
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    sent_cnt_d = sent_cnt_q;
    guard_d    = guard_q;
    case (state_q)
      IDLE: begin
        if (TxRdy && grant_valid) begin
          state_d    = LOAD;
          last_d     = grant_idx;
          tx_data_d  = req_data[8*int'(grant_idx) +: 8];
          // Counted on entry so the new count is visible alongside tx_load.
          sent_cnt_d = sent_cnt_q + 16'd1;
        end
      end
      LOAD: begin
        guard_d = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!TxRdy) begin
          state_d = WAIT_HIGH;
          guard_d = '0;
        end else if (guard_q == GW'(GUARD - 1)) begin
          // Engine never signalled busy; assume it swallowed the byte.
          state_d = IDLE;
          guard_d = '0;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      WAIT_HIGH: begin
        if (TxRdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= IW'(NREQ - 1);
      tx_data_q  <= '0;
      sent_cnt_q <= '0;
      guard_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      sent_cnt_q <= sent_cnt_d;
      guard_q    <= guard_d;
    end
  end

  assign tx_load  = (state_q == LOAD);
  assign ack      = tx_load ? (ONE_HOT0 << last_q) : '0;
  assign busy     = (state_q != IDLE);
  assign tx_data  = tx_data_q;
  assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant latency, round-robin order,
// TxRdy gating, guard timeout, mid-flight reset and counter wrap.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        TxRdy;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic [3:0]  ack;
  logic        busy;
  logic [15:0] sent_cnt;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.NREQ(4), .GUARD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .TxRdy    (TxRdy),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .ack      (ack),
    .busy     (busy),
    .sent_cnt (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Bounded wait for the next load strobe; an expired bound is a failed check.
  task automatic wait_load(input string tag);
    int n = 0;
    while (tx_load !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, tx_load}, 32'd1);
  endtask

  // Engine model: busy for a few cycles after each load, then ready again.
  task automatic engine_cycle();
    TxRdy = 1'b0;
    repeat (3) @(negedge clk);
    TxRdy = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    TxRdy    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx_load", tx_load, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_sent_cnt", sent_cnt, 0);

    // Single source: grant one cycle after the request.
    reset = 1'b0;
    req   = 4'b0001;
    req_data[7:0] = 8'h41;
    @(negedge clk);
    check("single_tx_load", tx_load, 1);
    check("single_ack", ack, 4'b0001);
    check("single_tx_data", tx_data, 8'h41);
    check("single_sent_cnt", sent_cnt, 1);
    check("single_busy", busy, 1);
    req   = 4'b0000;
    TxRdy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("single_no_reload", tx_load, 0);
      check("single_busy_hold", busy, 1);
    end
    TxRdy = 1'b1;
    @(negedge clk);
    check("single_busy_drop", busy, 0);

    // Round-robin with all four sources requesting.
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    req      = 4'b1111;
    req_data = 32'h13121110;
    TxRdy    = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      wait_load($sformatf("rr%0d_load", k));
      check($sformatf("rr%0d_ack", k), ack, 32'd1 << (k % 4));
      check($sformatf("rr%0d_data", k), tx_data, 32'h10 + (k % 4));
      if (k == 5) req = 4'b0000;
      engine_cycle();
    end
    @(negedge clk);
    check("rr_idle", busy, 0);

    // Gating: no grant while the engine is not ready.
    TxRdy = 1'b0;
    req   = 4'b0100;
    repeat (50) begin
      @(negedge clk);
      check("gate_no_load", tx_load, 0);
      check("gate_no_busy", busy, 0);
    end
    TxRdy = 1'b1;
    @(negedge clk);
    check("gate_tx_load", tx_load, 1);
    check("gate_ack", ack, 4'b0100);
    check("gate_data", tx_data, 8'h12);

    // Guard timeout: TxRdy never falls; IDLE at LOAD+5, next grant at LOAD+6.
    req = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("guard_wait%0d_busy", k), busy, 1);
      check($sformatf("guard_wait%0d_load", k), tx_load, 0);
    end
    @(negedge clk);
    check("guard_idle_busy", busy, 0);
    check("guard_idle_load", tx_load, 0);
    @(negedge clk);
    check("guard_regrant_load", tx_load, 1);
    check("guard_regrant_ack", ack, 4'b0010);
    check("guard_regrant_data", tx_data, 8'h11);

    // Reset while in WAIT_HIGH.
    req   = 4'b0011;
    TxRdy = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_pre_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx_load", tx_load, 0);
    check("midrst_ack", ack, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_sent_cnt", sent_cnt, 0);
    reset = 1'b0;
    TxRdy = 1'b1;
    @(negedge clk);
    check("midrst_first_load", tx_load, 1);
    check("midrst_first_ack", ack, 4'b0001);
    check("midrst_first_data", tx_data, 8'h10);
    check("midrst_first_cnt", sent_cnt, 1);

    // Counter wrap from 0xFFFF.
    req = 4'b0000;
    repeat (5) @(negedge clk);
    check("wrap_pre_idle", busy, 0);
    force dut.sent_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.sent_cnt_q;
    check("wrap_preload", sent_cnt, 16'hFFFF);
    req = 4'b1000;
    @(negedge clk);
    check("wrap_cnt", sent_cnt, 16'h0000);
    check("wrap_tx_load", tx_load, 1);
    check("wrap_ack", ack, 4'b1000);
    check("wrap_data", tx_data, 8'h13);
    check("wrap_busy", busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
